// File: rtl/airbag_deploy_ctrl.sv
// airbag_deploy_ctrl: debounced crash detection firing latched per-seat squibs for a fixed pulse, with optional sensor-fault lockout
// Ports: clk, rst (async, active-high), arm, seatbelt[NUM_SEATS], sensor, brake (hard braking; "break" is a reserved word),
//        clear -> airbag[NUM_SEATS], state[3] (IDLE=0 ARMED=1 FIRE=2 DONE=3 FAULT=4), deployed, fault.
// Macro AIRBAG_FAULT_EN adds the sensor-without-brake fault counter and FAULT state; otherwise fault is tied 0.
module airbag_deploy_ctrl #(
  parameter int NUM_SEATS       = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIRE_CYCLES     = 8,
  parameter int FAULT_CYCLES    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [NUM_SEATS-1:0] seatbelt,
  input  logic                 sensor,
  input  logic                 brake,
  input  logic                 clear,
  output logic [NUM_SEATS-1:0] airbag,
  output logic [2:0]           state,
  output logic                 deployed,
  output logic                 fault
);
  localparam int M0   = DEBOUNCE_CYCLES > FIRE_CYCLES ? DEBOUNCE_CYCLES : FIRE_CYCLES;
  localparam int MAXC = M0 > FAULT_CYCLES ? M0 : FAULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_ARMED = 3'd1, S_FIRE = 3'd2, S_DONE = 3'd3, S_FAULT = 3'd4} st_t;
  st_t st, st_n;
  logic [CW-1:0] dcnt, dcnt_n, fcnt, fcnt_n;
  logic [NUM_SEATS-1:0] mask, mask_n;
  logic trig;
  assign trig  = sensor & brake;
  assign state = st;
`ifdef AIRBAG_FAULT_EN
  logic [CW-1:0] qcnt, qcnt_n;
`endif
  // Counters stop at their terminal value because reaching it always changes state.
  always_comb begin
    st_n   = st;
    dcnt_n = dcnt;
    fcnt_n = fcnt;
    mask_n = mask;
`ifdef AIRBAG_FAULT_EN
    qcnt_n = qcnt;
`endif
    case (st)
      S_IDLE: st_n = arm ? S_ARMED : S_IDLE;
      S_ARMED: begin
        dcnt_n = (arm && trig) ? dcnt + 1'b1 : '0;
`ifdef AIRBAG_FAULT_EN
        qcnt_n = (arm && sensor && !brake) ? qcnt + 1'b1 : '0;
`endif
        if (!arm) st_n = S_IDLE;
        else if (trig && dcnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          st_n   = S_FIRE;
          mask_n = seatbelt;
          dcnt_n = '0;
          fcnt_n = '0;
        end
`ifdef AIRBAG_FAULT_EN
        else if (sensor && !brake && qcnt == CW'(FAULT_CYCLES - 1)) begin
          st_n   = S_FAULT;
          qcnt_n = '0;
        end
`endif
      end
      S_FIRE: begin
        fcnt_n = fcnt + 1'b1;
        if (fcnt == CW'(FIRE_CYCLES - 1)) begin
          st_n   = S_DONE;
          fcnt_n = '0;
          mask_n = '0;
        end
      end
      S_DONE:  st_n = clear ? S_IDLE : S_DONE;
      S_FAULT: st_n = clear ? S_IDLE : S_FAULT;
      default: st_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      dcnt     <= '0;
      fcnt     <= '0;
      mask     <= '0;
      airbag   <= '0;
      deployed <= 1'b0;
    end else begin
      st       <= st_n;
      dcnt     <= dcnt_n;
      fcnt     <= fcnt_n;
      mask     <= mask_n;
      airbag   <= st_n == S_FIRE ? mask_n : '0;
      deployed <= st_n == S_DONE;
    end
  end
`ifdef AIRBAG_FAULT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt  <= '0;
      fault <= 1'b0;
    end else begin
      qcnt  <= qcnt_n;
      fault <= st_n == S_FAULT;
    end
  end
`else
  assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_airbag_deploy_ctrl.sv
// tb_airbag_deploy_ctrl: vector table, corner sequences and random stimulus against a timestamp-based reference model
module tb_airbag_deploy_ctrl;
  localparam int D  = 4;
  localparam int F  = 8;
  localparam int FC = 16;
  logic clk = 1'b0;
  logic rst, arm, sensor, brake, clear;
  logic [3:0] seatbelt, airbag;
  logic [2:0] state;
  logic deployed, fault;
  int tests = 0;
  int fails = 0;
  int m, n, lz, lf, fe;
  logic [3:0] mmask;
  typedef struct {
    logic a;
    logic [3:0] sb;
    logic s, b, c;
    logic [3:0] e_ab;
    logic [2:0] e_st;
  } vec_t;
  vec_t vt[16];
  always #5 clk = ~clk;
  airbag_deploy_ctrl dut (
    .clk(clk), .rst(rst), .arm(arm), .seatbelt(seatbelt), .sensor(sensor), .brake(brake),
    .clear(clear), .airbag(airbag), .state(state), .deployed(deployed), .fault(fault)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  // Reference model: a crash streak length is the distance from the last non-trig edge,
  // the pulse is a window of F edges after the firing edge.
  task automatic model(input logic a, input logic [3:0] sb, input logic s, input logic b, input logic c);
    n++;
    case (m)
      0: if (a) begin m = 1; lz = n; lf = n; end
      1: if (!a) m = 0;
         else begin
           if (!(s && b)) lz = n;
           if (!(s && !b)) lf = n;
           if (n - lz == D) begin m = 2; mmask = sb; fe = n; end
`ifdef AIRBAG_FAULT_EN
           else if (n - lf == FC) m = 4;
`endif
         end
      2: if (n - fe == F) m = 3;
      default: if (c) m = 0;
    endcase
  endtask
  task automatic cmp_model(input string tag);
    chk({tag, ".airbag"}, airbag, m == 2 ? mmask : 4'b0);
    chk({tag, ".state"}, state, m);
    chk({tag, ".deployed"}, deployed, m == 3);
    chk({tag, ".fault"}, fault, m == 4);
  endtask
  task automatic step(input logic a, input logic [3:0] sb, input logic s, input logic b, input logic c, input string tag);
    arm = a; seatbelt = sb; sensor = s; brake = b; clear = c;
    @(posedge clk);
    model(a, sb, s, b, c);
    #1;
    cmp_model(tag);
  endtask
  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; seatbelt = '0; sensor = 1'b0; brake = 1'b0; clear = 1'b0;
    m = 0;
    @(posedge clk);
    #1;
    cmp_model("reset");
    rst = 1'b0;
  endtask
  initial begin
    n = 0; lz = 0; lf = 0; fe = 0; mmask = '0;
    vt[0] = '{1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd1};
    for (int i = 1; i < 4; i++) vt[i] = '{1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b0000, 3'd1};
    vt[4] = '{1'b1, 4'b0101, 1'b1, 1'b1, 1'b0, 4'b0101, 3'd2};
    for (int i = 5; i < 12; i++) vt[i] = '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 4'b0101, 3'd2};
    vt[12] = '{1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd3};
    vt[13] = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 3'd3};
    vt[14] = '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 3'd0};
    vt[15] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 3'd0};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(vt[i].a, vt[i].sb, vt[i].s, vt[i].b, vt[i].c, "vec");
      chk($sformatf("vec%0d.airbag", i), airbag, vt[i].e_ab);
      chk($sformatf("vec%0d.state", i), state, vt[i].e_st);
      chk($sformatf("vec%0d.deployed", i), deployed, vt[i].e_st == 3'd3);
    end
    // broken streak: 3 on, 1 off, 3 on holds ARMED, fourth edge fires
    do_reset();
    step(1, 4'b0011, 0, 0, 0, "brk");
    for (int i = 0; i < 3; i++) step(1, 4'b0011, 1, 1, 0, "brk");
    step(1, 4'b0011, 1, 0, 0, "brk");
    for (int i = 0; i < 3; i++) step(1, 4'b0011, 1, 1, 0, "brk");
    chk("brk.hold_state", state, 3'd1);
    step(1, 4'b0011, 1, 1, 0, "brk");
    chk("brk.fire_state", state, 3'd2);
    chk("brk.fire_airbag", airbag, 4'b0011);
    // async reset in third FIRE cycle, no refire afterwards
    do_reset();
    step(1, 4'b1111, 0, 0, 0, "ar");
    for (int i = 0; i < 6; i++) step(1, 4'b1111, 1, 1, 0, "ar");
    chk("ar.mid_fire", airbag, 4'b1111);
    #2 rst = 1'b1;
    #1;
    chk("ar.async_airbag", airbag, 4'b0000);
    chk("ar.async_state", state, 3'd0);
    m = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 4'b1111, 1, 1, 0, "ar");
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 0, 0, 0, "ar");
    chk("ar.no_refire", airbag, 4'b0000);
    // belt change after firing is not seen; clear from DONE
    do_reset();
    step(1, 4'b0001, 0, 0, 0, "mk");
    for (int i = 0; i < 4; i++) step(1, 4'b0001, 1, 1, 0, "mk");
    for (int i = 0; i < 7; i++) begin
      step(1, 4'b1111, 1, 1, 0, "mk");
      chk("mk.latched", airbag, 4'b0001);
    end
    step(1, 4'b1111, 0, 0, 0, "mk");
    chk("mk.done", state, 3'd3);
    step(0, 4'b0000, 0, 0, 1, "mk");
    chk("mk.clear", state, 3'd0);
    // disarm on the fourth trig edge wins
    do_reset();
    step(1, 4'b1111, 0, 0, 0, "dis");
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 1, 1, 0, "dis");
    step(0, 4'b1111, 1, 1, 0, "dis");
    chk("dis.state", state, 3'd0);
    chk("dis.airbag", airbag, 4'b0000);
    // sensor without brake; fault build locks out firing
    do_reset();
    step(1, 4'b1111, 0, 0, 0, "flt");
    for (int i = 0; i < FC; i++) step(1, 4'b1111, 1, 0, 0, "flt");
`ifdef AIRBAG_FAULT_EN
    chk("flt.state", state, 3'd4);
    chk("flt.fault", fault, 1'b1);
`else
    chk("flt.nofault", fault, 1'b0);
`endif
    for (int i = 0; i < 10; i++) step(1, 4'b1111, 1, 1, 0, "flt");
    step(1, 4'b1111, 0, 0, 1, "flt");
    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 15) != 0, 4'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, "rnd");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
